clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//   Runtime-programmable clock-enable divider, successor of the fixed divide-by-4 1 MHz generator.
//   Produces a registered divided clock CLK_OUT from CLK with programmable period and high time.
//   Also produces single-cycle RISE/FALL strobes for logic that stays in the CLK domain.
//   Config changes are shadowed and applied only at a period boundary, so CLK_OUT never glitches.
// PARAMETERS
//   CNT_W     8   width of counter, DIV_IN and HIGH_IN
//   DEF_DIV   4   period in CLK cycles after reset; 2 <= DEF_DIV <= 2**CNT_W-1
//   DEF_HIGH  2   CLK_OUT high cycles per period after reset; 1 <= DEF_HIGH < DEF_DIV
// PORTS
//   CLK      in   1      system clock
//   RESET    in   1      reset, synchronous, active-high
//   EN       in   1      1 = run divider; 0 = stop, CLK_OUT held low
//   DIV_IN   in   CNT_W  requested period, sampled when LOAD=1
//   HIGH_IN  in   CNT_W  requested high time, sampled when LOAD=1
//   LOAD     in   1      config update request, level-sampled each cycle
//   BUSY     out  1      valid config shadowed, not yet applied
//   CFG_ERR  out  1      1-cycle pulse: LOAD rejected (bad values)
//   CLK_OUT  out  1      divided clock, registered
//   RISE     out  1      1 in the cycle CLK_OUT goes 0->1
//   FALL     out  1      1 in the cycle CLK_OUT goes 1->0
// BEHAVIOUR
//   Reset: cnt=0, div=DEF_DIV, high=DEF_HIGH, shadow cleared. State IDLE.
//   Reset: CLK_OUT=0, RISE=0, FALL=0, BUSY=0, CFG_ERR=0.
//   Reset mid-operation discards any pending config. No FALL pulse is generated on reset.
//   Counter: when EN=1, cnt_n = (cnt==div-1) ? 0 : cnt+1.
//   Output: CLK_OUT <= (cnt_n >= div-high). RISE/FALL are registered from the same comparison.
//   Result: CLK_OUT is low for div-high cycles, then high for high cycles. Period = div.
//   Output is low whenever cnt=0.
//   Example, div=4 high=2: cnt 1,2,3,0,... gives CLK_OUT 0,1,1,0,...
//   First CLK_OUT rise is div-high+... = 2 cycles after EN is first seen high.
//   States:
//     IDLE (EN=0): cnt held at 0, CLK_OUT<=0. FALL pulses if CLK_OUT was 1.
//     RUN (EN=1, BUSY=0): free-running count.
//     PEND (EN=1, BUSY=1): counting with old config.
//   Transitions:
//     IDLE->RUN when EN=1. The first enabled cycle counts from cnt=0, so a fresh period starts.
//     RUN/PEND->IDLE when EN=0 (PEND keeps BUSY).
//     RUN->PEND on an accepted LOAD.
//     PEND->RUN at wrap (cnt==div-1 with EN=1). The shadow is copied into div/high.
//     That wrap's cnt_n=0 uses the new config. BUSY falls in the same edge.
//   LOAD validation: accept iff DIV_IN>=2, HIGH_IN>=1 and HIGH_IN<DIV_IN.
//     Accepted: shadow<=inputs, BUSY<=1 next cycle.
//     Rejected: CFG_ERR pulses 1 cycle later. Shadow and BUSY are unchanged.
//   LOAD while BUSY: new valid values overwrite the shadow (last wins). Only one apply occurs.
//   LOAD in the same cycle as a wrap: the latch takes effect, but apply waits for the next wrap.
//   LOAD while in IDLE: the shadow is applied in the next cycle (no period in progress).
//     BUSY is 1 for exactly that one cycle.
//   LOAD held high multiple cycles: each cycle is a separate request (re-latches, same result).
//   Wrap-around: cnt never exceeds div-1. div=2**CNT_W-1 requires no extra bit.
//   Compare div-high uses CNT_W-bit unsigned arithmetic; validity guarantees no underflow.
// TESTING
//   Reset, EN=1, defaults -> CLK_OUT 0,0,1,1 repeating (period 4).
//     RISE on every 4th cycle, FALL 2 cycles after each RISE.
//   LOAD DIV_IN=10 HIGH_IN=3 mid-period -> BUSY=1 until next wrap.
//     Then period 10, 7 low / 3 high. The old period completes intact.
//   LOAD DIV_IN=1, LOAD DIV_IN=5 HIGH_IN=5, LOAD HIGH_IN=0 -> one CFG_ERR pulse each.
//     BUSY stays 0 and the waveform is unchanged.
//   Two LOADs (6/2 then 8/4) in one period -> only 8/4 is applied at the wrap.
//   EN dropped while CLK_OUT=1 -> FALL next cycle, CLK_OUT stays 0.
//     Re-enable -> first RISE after div-high cycles.
//   RESET while BUSY=1 with div=10 -> BUSY=0 and CLK_OUT=0 next cycle. Defaults 4/2 resume.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable clock-enable divider with shadowed period/high-time config.
// CLK_OUT is registered; RISE/FALL strobes serve logic in the CLK domain.
module clk_div_prog #(
  parameter int CNT_W    = 8,
  parameter int DEF_DIV  = 4,
  parameter int DEF_HIGH = 2
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [CNT_W-1:0] DIV_IN,
  input  logic [CNT_W-1:0] HIGH_IN,
  input  logic             LOAD,
  output logic             BUSY,
  output logic             CFG_ERR,
  output logic             CLK_OUT,
  output logic             RISE,
  output logic             FALL
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO   = CNT_W'(2);
  localparam logic [CNT_W-1:0] D_RST = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] H_RST = CNT_W'(DEF_HIGH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] sdiv_q, sdiv_d;
  logic [CNT_W-1:0] shigh_q, shigh_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  logic             acc;
  logic             wrap;
  logic             apply;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    high_d  = high_q;
    sdiv_d  = sdiv_q;
    shigh_d = shigh_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    out_d   = 1'b0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    acc = LOAD && (DIV_IN >= TWO) && (HIGH_IN >= ONE)
          && (HIGH_IN < DIV_IN);
    wrap = (cnt_q == div_q - ONE);
    // Idle has no period in progress, so a pending config lands at once.
    apply = busy_q && ((state_q == IDLE) || (EN && wrap));

    if (apply) begin
      div_d  = sdiv_q;
      high_d = shigh_q;
    end
    if (acc) begin
      sdiv_d  = DIV_IN;
      shigh_d = HIGH_IN;
    end
    busy_d = acc || (busy_q && !apply);
    err_d  = LOAD && !acc;

    if (EN) begin
      cnt_d = wrap ? '0 : cnt_q + ONE;
      out_d = (cnt_d >= div_d - high_d);
    end else begin
      cnt_d = '0;
    end
    rise_d = out_d && !out_q;
    fall_d = !out_d && out_q;

    if (!EN) begin
      state_d = IDLE;
    end else if (busy_d) begin
      state_d = PEND;
    end else begin
      state_d = RUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= D_RST;
      high_q  <= H_RST;
      sdiv_q  <= '0;
      shigh_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      high_q  <= high_d;
      sdiv_q  <= sdiv_d;
      shigh_q <= shigh_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign BUSY    = busy_q;
  assign CFG_ERR = err_q;
  assign CLK_OUT = out_q;
  assign RISE    = rise_q;
  assign FALL    = fall_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: vector table, corner sequences, and
// randomized traffic against a period-position reference model.
module tb_clk_div_prog;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       EN = 1'b0;
  logic [7:0] DIV_IN = '0;
  logic [7:0] HIGH_IN = '0;
  logic       LOAD = 1'b0;
  logic       BUSY, CFG_ERR, CLK_OUT, RISE, FALL;

  int tests = 0;
  int fails = 0;

  clk_div_prog #(.CNT_W(8), .DEF_DIV(4), .DEF_HIGH(2)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN),
    .DIV_IN(DIV_IN), .HIGH_IN(HIGH_IN), .LOAD(LOAD),
    .BUSY(BUSY), .CFG_ERR(CFG_ERR), .CLK_OUT(CLK_OUT),
    .RISE(RISE), .FALL(FALL)
  );

  always #5 CLK = ~CLK;

  // Reference: position within the current period plus applied config.
  int m_div, m_high, m_sdiv, m_shigh, m_pos;
  bit m_pend, m_was, m_out, m_rise, m_fall, m_err;

  function automatic void model_step(bit rst, bit en, bit ld, int d, int h);
    bit ok, bnd, nout;
    if (rst) begin
      m_div = 4; m_high = 2; m_pend = 0; m_pos = 0; m_was = 0;
      m_out = 0; m_rise = 0; m_fall = 0; m_err = 0;
      return;
    end
    ok = ld && d >= 2 && h >= 1 && h < d;
    m_err = ld && !ok;
    bnd = !m_was || (en && m_pos == m_div - 1);
    m_pos = en ? (m_pos + 1) % m_div : 0;
    if (m_pend && bnd) begin
      m_div = m_sdiv; m_high = m_shigh; m_pend = 0;
    end
    if (ok) begin
      m_sdiv = d; m_shigh = h; m_pend = 1;
    end
    nout = en && (m_pos >= m_div - m_high);
    m_rise = nout && !m_out;
    m_fall = !nout && m_out;
    m_out = nout;
    m_was = en;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(bit rst, bit en, bit ld, int d, int h);
    RESET = rst; EN = en; LOAD = ld;
    DIV_IN = 8'(d); HIGH_IN = 8'(h);
    @(posedge CLK);
    model_step(rst, en, ld, d, h);
    #1;
    chk("model", {27'd0, BUSY, CFG_ERR, CLK_OUT, RISE, FALL},
        {27'd0, m_pend, m_err, m_out, m_rise, m_fall});
  endtask

  task automatic measure(output int per, output int hi);
    int n;
    per = 0; hi = 0; n = 0;
    while (!RISE && n < 600) begin
      drive(0, 1, 0, 0, 0); n++;
    end
    if (!RISE) begin
      chk("rise_timeout", 0, 1);
      return;
    end
    hi = 1;
    n = 0;
    do begin
      drive(0, 1, 0, 0, 0);
      per++;
      if (!RISE && CLK_OUT) hi++;
    end while (!RISE && per < 600);
  endtask

  typedef struct {
    bit en, ld;
    int d, h;
    logic [4:0] exp; // busy, err, clk, rise, fall
  } vec_t;

  vec_t vt[22];

  function automatic vec_t mk(bit en, bit ld, int d, int h, logic [4:0] e);
    vec_t v;
    v.en = en; v.ld = ld; v.d = d; v.h = h; v.exp = e;
    return v;
  endfunction

  initial begin
    int per, hi, n;
    vt[0]  = mk(1, 0, 0, 0, 5'b00000);
    vt[1]  = mk(1, 0, 0, 0, 5'b00110);
    vt[2]  = mk(1, 0, 0, 0, 5'b00100);
    vt[3]  = mk(1, 0, 0, 0, 5'b00001);
    vt[4]  = mk(1, 0, 0, 0, 5'b00000);
    vt[5]  = mk(1, 0, 0, 0, 5'b00110);
    vt[6]  = mk(1, 1, 1, 1, 5'b01100);
    vt[7]  = mk(1, 1, 5, 5, 5'b01001);
    vt[8]  = mk(1, 1, 5, 0, 5'b01000);
    vt[9]  = mk(1, 0, 0, 0, 5'b00110);
    vt[10] = mk(1, 1, 10, 3, 5'b10100);
    vt[11] = mk(1, 0, 0, 0, 5'b00001);
    for (int i = 12; i < 18; i++) vt[i] = mk(1, 0, 0, 0, 5'b00000);
    vt[18] = mk(1, 0, 0, 0, 5'b00110);
    vt[19] = mk(1, 0, 0, 0, 5'b00100);
    vt[20] = mk(1, 0, 0, 0, 5'b00100);
    vt[21] = mk(1, 0, 0, 0, 5'b00001);

    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("reset_state", {27'd0, BUSY, CFG_ERR, CLK_OUT, RISE, FALL}, 0);

    for (int i = 0; i < 22; i++) begin
      drive(0, vt[i].en, vt[i].ld, vt[i].d, vt[i].h);
      chk($sformatf("vec%0d", i),
          {27'd0, BUSY, CFG_ERR, CLK_OUT, RISE, FALL}, {27'd0, vt[i].exp});
    end

    // Two loads in one period: only the last one is applied.
    drive(0, 1, 1, 6, 2);
    chk("busy_after_load", 32'(BUSY), 1);
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 8, 4);
    measure(per, hi);
    measure(per, hi);
    chk("last_wins_period", per, 8);
    chk("last_wins_high", hi, 4);

    // Drop EN while high, then re-enable.
    n = 0;
    while (!CLK_OUT && n < 50) begin
      drive(0, 1, 0, 0, 0); n++;
    end
    chk("wait_high", 32'(CLK_OUT), 1);
    drive(0, 0, 0, 0, 0);
    chk("en_drop_fall", 32'(FALL), 1);
    chk("en_drop_low", 32'(CLK_OUT), 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0);
      chk("idle_low", {30'd0, CLK_OUT, FALL}, 0);
    end
    drive(0, 1, 0, 0, 0);
    n = 1;
    while (!RISE && n < 50) begin
      drive(0, 1, 0, 0, 0); n++;
    end
    chk("reenable_rise_delay", n, 4);

    // Load while idle: BUSY for exactly one cycle.
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 1, 5, 2);
    chk("idle_load_busy", 32'(BUSY), 1);
    drive(0, 0, 0, 0, 0);
    chk("idle_load_applied", 32'(BUSY), 0);
    measure(per, hi);
    measure(per, hi);
    chk("idle_cfg_period", per, 5);
    chk("idle_cfg_high", hi, 2);

    // Reset while a config is pending with div=10.
    drive(0, 1, 1, 10, 3);
    n = 0;
    while (BUSY && n < 20) begin
      drive(0, 1, 0, 0, 0); n++;
    end
    chk("div10_applied", 32'(BUSY), 0);
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 6, 2);
    chk("busy_before_reset", 32'(BUSY), 1);
    drive(1, 1, 0, 0, 0);
    chk("reset_busy", 32'(BUSY), 0);
    chk("reset_out", {29'd0, CLK_OUT, RISE, FALL}, 0);
    measure(per, hi);
    measure(per, hi);
    chk("post_reset_period", per, 4);
    chk("post_reset_high", hi, 2);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 4000; i++) begin
      bit r, e, l;
      int d, h;
      r = ($urandom % 600) == 0;
      e = ($urandom % 16) != 0;
      l = ($urandom % 10) == 0;
      d = ($urandom % 5 == 0) ? int'($urandom % 256) : int'($urandom % 12);
      h = ($urandom % 5 == 0) ? int'($urandom % 256) : int'($urandom % 12);
      drive(r, e, l, d, h);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
